// File: rtl/acc_pkg.sv
// Shared constants for the accumulator execute stage.
// Holds the opcodes, ALU control codes, FSM state type and datapath width.
package acc_pkg;

    localparam int N = 8;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    // Bit 0 of every ALU control code is the ALU carry-in.
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/acc_exec_unit_mul_seq.sv
// Shift-add multiply sequencer: keeps product, shifted multiplicand, multiplier,
// iteration counter and sticky carry; the adds themselves go through the external ALU.
module mul_seq
    import acc_pkg::*;
#(
    parameter int W = acc_pkg::N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         active,
    input  logic [W-1:0] multiplicand,
    input  logic [W-1:0] multiplier,
    input  logic [W-1:0] alu_sum,
    input  logic         alu_carry,
    output logic [W-1:0] product,
    output logic [W-1:0] shifted_mcand,
    output logic         last,
    output logic [W-1:0] product_next,
    output logic         carry_next
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  p_reg;
    logic [W-1:0]  m_reg;
    logic [W-1:0]  q_reg;
    logic [CW-1:0] cnt_reg;
    logic          mul_c_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg     <= '0;
            m_reg     <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            mul_c_reg <= 1'b0;
        end else if (start) begin
            p_reg     <= '0;
            m_reg     <= multiplicand;
            q_reg     <= multiplier;
            cnt_reg   <= '0;
            mul_c_reg <= 1'b0;
        end else if (active) begin
            if (q_reg[0]) begin
                p_reg     <= alu_sum;
                mul_c_reg <= mul_c_reg | alu_carry;
            end
            m_reg   <= m_reg << 1;
            q_reg   <= q_reg >> 1;
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign product       = p_reg;
    assign shifted_mcand = m_reg;
    assign last          = active && (cnt_reg == CW'(W - 1));
    // The final iteration's add must be folded in when the result retires on the same edge.
    assign product_next  = q_reg[0] ? alu_sum : p_reg;
    assign carry_next    = mul_c_reg | (q_reg[0] & alu_carry);

endmodule

// File: rtl/acc_exec_unit.sv
// Execute stage of the accumulator processor: command handshake, ALU operand/control
// drive, accumulator and flag registers, and sequencing of the iterative multiply.
module acc_exec_unit #(
    parameter int N = 8
) (
    input  logic         clk_in,
    input  logic         reset_n_in,
    input  logic         cmd_valid_in,
    output logic         cmd_ready_out,
    input  logic [2:0]   cmd_op_in,
    input  logic [N-1:0] cmd_operand_in,
    output logic [N-1:0] alu_a_out,
    output logic [N-1:0] alu_b_out,
    output logic [2:0]   alu_ctrl_out,
    input  logic [N-1:0] alu_sum_in,
    input  logic         alu_carry_in,
    input  logic         alu_overflow_in,
    input  logic         alu_zero_in,
    output logic [N-1:0] acc_out,
    output logic         carry_out,
    output logic         overflow_out,
    output logic         zero_out,
    output logic         done_out
);
    import acc_pkg::*;

    state_t       state_reg;
    logic [2:0]   op_reg;
    logic [N-1:0] operand_reg;
    logic [N-1:0] acc_reg;
    logic         carry_reg;
    logic         overflow_reg;
    logic         zero_reg;
    logic         done_reg;

    logic         accept;
    logic         mul_start;
    logic         mul_active;
    logic [N-1:0] mul_product;
    logic [N-1:0] mul_mcand;
    logic         mul_last;
    logic [N-1:0] mul_product_next;
    logic         mul_carry_next;

    assign accept     = cmd_valid_in && (state_reg == ST_IDLE);
    assign mul_start  = accept && (cmd_op_in == OP_MUL);
    assign mul_active = (state_reg == ST_MUL);

    mul_seq #(.W(N)) u_mul_seq (
        .clk           (clk_in),
        .rst_n         (reset_n_in),
        .start         (mul_start),
        .active        (mul_active),
        .multiplicand  (acc_reg),
        .multiplier    (cmd_operand_in),
        .alu_sum       (alu_sum_in),
        .alu_carry     (alu_carry_in),
        .product       (mul_product),
        .shifted_mcand (mul_mcand),
        .last          (mul_last),
        .product_next  (mul_product_next),
        .carry_next    (mul_carry_next)
    );

    // During MUL the ALU is borrowed to accumulate the partial product.
    assign alu_a_out = mul_active ? mul_product : acc_reg;
    assign alu_b_out = mul_active ? mul_mcand   : operand_reg;

    always_comb begin
        alu_ctrl_out = ALU_PASSB;
        if (state_reg == ST_MUL) begin
            alu_ctrl_out = ALU_ADD;
        end else if (state_reg == ST_EXEC) begin
            case (op_reg)
                OP_ADD:  alu_ctrl_out = ALU_ADD;
                OP_SUB:  alu_ctrl_out = ALU_SUB;
                OP_AND:  alu_ctrl_out = ALU_AND;
                OP_OR:   alu_ctrl_out = ALU_OR;
                default: alu_ctrl_out = ALU_PASSB;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_NOP;
            operand_reg  <= '0;
            acc_reg      <= '0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid_in) begin
                        op_reg      <= cmd_op_in;
                        operand_reg <= cmd_operand_in;
                        state_reg   <= (cmd_op_in == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_reg)
                        OP_ADD, OP_SUB: begin
                            acc_reg      <= alu_sum_in;
                            carry_reg    <= alu_carry_in;
                            overflow_reg <= alu_overflow_in;
                            zero_reg     <= alu_zero_in;
                        end
                        OP_AND, OP_OR, OP_LDA: begin
                            acc_reg      <= alu_sum_in;
                            carry_reg    <= 1'b0;
                            overflow_reg <= 1'b0;
                            zero_reg     <= alu_zero_in;
                        end
                        OP_CLR: begin
                            acc_reg      <= '0;
                            carry_reg    <= 1'b0;
                            overflow_reg <= 1'b0;
                            zero_reg     <= 1'b1;
                        end
                        default: ;
                    endcase
                    done_reg  <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_MUL: begin
                    if (mul_last) begin
                        acc_reg      <= mul_product_next;
                        carry_reg    <= mul_carry_next;
                        overflow_reg <= 1'b0;
                        zero_reg     <= (mul_product_next == '0);
                        done_reg     <= 1'b1;
                        state_reg    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_out = (state_reg == ST_IDLE);
    assign acc_out       = acc_reg;
    assign carry_out     = carry_reg;
    assign overflow_out  = overflow_reg;
    assign zero_out      = zero_reg;
    assign done_out      = done_reg;

endmodule

// File: tb/tb_acc_exec_unit.sv
// Bench for acc_exec_unit: models the external 8-bit ALU and compares the unit
// against an arithmetic reference of each command's effect on accumulator and flags.
module tb_acc_exec_unit;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_operand;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_sum;
    logic       alu_carry;
    logic       alu_ovf;
    logic       alu_zero;
    logic [7:0] acc;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       done;

    int check_count = 0;
    int error_count = 0;

    int m_acc;
    int m_c;
    int m_v;
    int m_z;

    acc_exec_unit #(.N(8)) dut (
        .clk_in          (clk),
        .reset_n_in      (reset_n),
        .cmd_valid_in    (cmd_valid),
        .cmd_ready_out   (cmd_ready),
        .cmd_op_in       (cmd_op),
        .cmd_operand_in  (cmd_operand),
        .alu_a_out       (alu_a),
        .alu_b_out       (alu_b),
        .alu_ctrl_out    (alu_ctrl),
        .alu_sum_in      (alu_sum),
        .alu_carry_in    (alu_carry),
        .alu_overflow_in (alu_ovf),
        .alu_zero_in     (alu_zero),
        .acc_out         (acc),
        .carry_out       (carry),
        .overflow_out    (overflow),
        .zero_out        (zero),
        .done_out        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU behaviour
    logic [8:0] alu_t;
    always_comb begin
        alu_t     = 9'd0;
        alu_sum   = 8'd0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_ctrl)
            3'b000: alu_sum = alu_a & alu_b;
            3'b100: alu_sum = alu_a | alu_b;
            3'b110: alu_sum = alu_b;
            3'b010: begin
                alu_t     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_sum   = alu_t[7:0];
                alu_carry = alu_t[8];
                alu_ovf   = (alu_a[7] == alu_b[7]) && (alu_t[7] != alu_a[7]);
            end
            3'b011: begin
                alu_t     = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
                alu_sum   = alu_t[7:0];
                alu_carry = alu_t[8];
                alu_ovf   = (alu_a[7] != alu_b[7]) && (alu_t[7] != alu_a[7]);
            end
            default: alu_sum = 8'd0;
        endcase
        alu_zero = (alu_sum == 8'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed8(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_c = 0; m_v = 0; m_z = 1;
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [7:0] b_in);
        int a, b, u, s, p, t, c;
        a = m_acc;
        b = int'(b_in);
        case (op)
            3'd1: begin m_acc = b; m_c = 0; m_v = 0; end
            3'd2: begin
                u = a + b; s = to_signed8(a) + to_signed8(b);
                m_acc = u % 256; m_c = (u > 255); m_v = (s > 127 || s < -128);
            end
            3'd3: begin
                u = a - b; s = to_signed8(a) - to_signed8(b);
                m_acc = (u + 256) % 256; m_c = (a >= b); m_v = (s > 127 || s < -128);
            end
            3'd4: begin m_acc = a & b; m_c = 0; m_v = 0; end
            3'd5: begin m_acc = a | b; m_c = 0; m_v = 0; end
            3'd6: begin
                p = 0; c = 0;
                for (int i = 0; i < 8; i++) begin
                    if (((b >> i) & 1) == 1) begin
                        t = p + ((a << i) % 256);
                        if (t > 255) c = 1;
                        p = t % 256;
                    end
                end
                m_acc = p; m_c = c; m_v = 0;
            end
            3'd7: begin m_acc = 0; m_c = 0; m_v = 0; end
            default: ;
        endcase
        m_z = (m_acc == 0);
    endtask

    // Called and returns at a negedge; issues one command and checks its retirement.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] b);
        int guard;
        int lat;
        int old_acc;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        old_acc     = m_acc;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = b;
        model_apply(op, b);
        @(posedge clk);
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_op      = 3'($urandom);
        cmd_operand = 8'($urandom);
        lat = 1;
        check("ready_low_busy", cmd_ready, 0);
        check("acc_hold_busy", acc, old_acc);
        case (op)
            3'd1: check("ctrl_lda", alu_ctrl, 3'b110);
            3'd2: check("ctrl_add", alu_ctrl, 3'b010);
            3'd3: check("ctrl_sub", alu_ctrl, 3'b011);
            3'd4: check("ctrl_and", alu_ctrl, 3'b000);
            3'd5: check("ctrl_or",  alu_ctrl, 3'b100);
            3'd6: check("ctrl_mul", alu_ctrl, 3'b010);
            default: ;
        endcase
        if (op == 3'd6) check("mul_b_mcand", alu_b, old_acc);
        else if (op != 3'd0 && op != 3'd7) check("alu_b_operand", alu_b, b);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, (op == 3'd6) ? 9 : 2);
        check("acc", acc, m_acc);
        check("carry", carry, m_c);
        check("overflow", overflow, m_v);
        check("zero", zero, m_z);
        check("ready_low_done", cmd_ready, 0);
        $display("cmd op=%0d b=0x%02h -> acc=0x%02h C=%0b V=%0b Z=%0b lat=%0d",
                 op, b, acc, carry, overflow, zero, lat);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("acc_stable_after", acc, m_acc);
    endtask

    initial begin
        int dones, last_ready, cyc, done_seen;

        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_operand = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_acc", acc, 0);
        check("rst_zero", zero, 1);
        check("rst_carry", carry, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_ctrl_passb", alu_ctrl, 3'b110);
        check("idle_ready", cmd_ready, 1);

        // Directed cases
        run_cmd(3'd1, 8'h7F);
        run_cmd(3'd2, 8'h01);
        check("add_overflow_acc", acc, 8'h80);
        check("add_overflow_v", overflow, 1);
        run_cmd(3'd1, 8'h05);
        run_cmd(3'd3, 8'h05);
        check("sub_zero_z", zero, 1);
        check("sub_zero_c", carry, 1);
        run_cmd(3'd1, 8'h0C);
        run_cmd(3'd6, 8'h0B);
        check("mul_0c_0b", acc, 8'h84);
        run_cmd(3'd1, 8'h10);
        run_cmd(3'd6, 8'h10);
        check("mul_10_10_z", zero, 1);
        check("mul_10_10_c", carry, 0);
        run_cmd(3'd1, 8'hFF);
        run_cmd(3'd6, 8'h03);
        check("mul_ff_03", acc, 8'hFD);
        check("mul_ff_03_c", carry, 1);
        run_cmd(3'd1, 8'hF0);
        run_cmd(3'd4, 8'h3C);
        check("and_result", acc, 8'h30);
        run_cmd(3'd5, 8'h0F);
        check("or_result", acc, 8'h3F);
        run_cmd(3'd0, 8'hAA);
        check("nop_keeps_acc", acc, 8'h3F);
        run_cmd(3'd7, 8'h55);

        // Back-to-back with valid held high
        cmd_valid   = 1'b1;
        cmd_op      = 3'd2;
        cmd_operand = 8'h01;
        dones = 0; last_ready = -1; cyc = 0;
        while (dones < 3 && cyc < 30) begin
            if (cmd_ready) begin
                if (last_ready >= 0) check("b2b_gap", cyc - last_ready, 3);
                last_ready = cyc;
            end
            if (done) begin
                dones++;
                model_apply(3'd2, 8'h01);
                check("b2b_acc", acc, m_acc);
                check("b2b_ready_done", cmd_ready, 0);
                $display("b2b retire %0d acc=0x%02h cyc=%0d", dones, acc, cyc);
                if (dones == 3) cmd_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        check("b2b_dones", dones, 3);
        check("b2b_final_acc", acc, 3);

        // Reset in the middle of a multiply
        run_cmd(3'd1, 8'h0C);
        cmd_valid   = 1'b1;
        cmd_op      = 3'd6;
        cmd_operand = 8'h0B;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midrst_acc", acc, 0);
        check("midrst_zero", zero, 1);
        check("midrst_done", done, 0);
        check("midrst_ready", cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_ready_after", cmd_ready, 1);
        $display("reset mid-MUL acc=0x%02h Z=%0b ready=%0b", acc, zero, cmd_ready);

        // Randomized commands
        for (int n = 0; n < 60; n++) begin
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
